// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the lab UART receiver and transmitter.
//   DATA_BITS        - payload bits per frame
//   CLKS_PER_BIT_DEF - default clk cycles per serial bit (one bit per clk)
//   rx_state_e       - receiver frame-tracking states
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus the receiver's byte/strobe outputs.
//   rx_line    - serial input, idle 1 (driven by the line side)
//   data_out   - last correctly received byte
//   data_valid - one-cycle strobe, data_out updated
//   frame_err  - one-cycle strobe, stop bit sampled as 0
//   busy       - frame in progress
// Modports: master = line driver / consumer, slave = receiver.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_line;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_line,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  rx_line,
        output data_out, data_valid, frame_err, busy
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: SYNC_STAGES-deep flop chain bringing an asynchronous serial
// line into the clk domain. Flops reset to 1 so a reset line reads as idle.
//   clk, rst - clock, asynchronous active-high reset
//   d        - asynchronous input
//   q        - synchronised output (d delayed by SYNC_STAGES flops)
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, downstream of the lab UART transmitter.
// Frames: start (0), 8 data bits LSB first, stop (1). Each bit is sampled
// once, HALF cycles after the bit boundary seen by the synchroniser.
//   clk, rst - clock, asynchronous active-high reset
//   rx_if    - slave side: rx_line in; data_out/data_valid/frame_err/busy out
// Parameters: CLKS_PER_BIT (1..1023), SYNC_STAGES (2..3).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  rx_if
);

    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;

    // START is entered one cycle after T0, so it counts HALF-1 more cycles.
    localparam logic [CW-1:0] HALF_M1  = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fe_q, fe_d;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_if.rx_line),
        .q   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // With HALF=0 the start sample is T0 itself, so skip START.
                if (!rx_s) state_d = (HALF == 0) ? DATA : START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;  // high here = glitch, drop it
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BRK: begin
                // A held-low line must not look like a stream of start bits.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = dv_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.busy       = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into two receivers (CLKS_PER_BIT 1 and 16)
// and compares the strobes they produce with a frame-level expectation.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if if1 ();
    uart_rx_if if16 ();

    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(SYNC)) dut1 (
        .clk (clk), .rst (rst), .rx_if (if1.slave)
    );
    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk (clk), .rst (rst), .rx_if (if16.slave)
    );

    int checks = 0;
    int errors = 0;

    // Observed events {frame_err, data_out} and the expected stream.
    logic [8:0] obs1[$], obs16[$], exp1[$], exp16[$];
    logic [7:0] good1 = 8'h00, good16 = 8'h00;   // last good byte per receiver

    int   pulse_bad1 = 0, pulse_bad16 = 0;
    logic dv1p = 1'b0, fe1p = 1'b0, dv16p = 1'b0, fe16p = 1'b0;

    always @(negedge clk) begin
        if (if1.data_valid || if1.frame_err) begin
            if ((if1.data_valid && if1.frame_err) || dv1p || fe1p) pulse_bad1 <= pulse_bad1 + 1;
            obs1.push_back({if1.frame_err, if1.data_out});
        end
        if (if16.data_valid || if16.frame_err) begin
            if ((if16.data_valid && if16.frame_err) || dv16p || fe16p) pulse_bad16 <= pulse_bad16 + 1;
            obs16.push_back({if16.frame_err, if16.data_out});
        end
        dv1p  <= if1.data_valid;
        fe1p  <= if1.frame_err;
        dv16p <= if16.data_valid;
        fe16p <= if16.frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) if16.rx_line = v;
        else     if1.rx_line  = v;
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        set_line(sel, v);
        repeat (n) @(negedge clk);
    endtask

    // Line-side transmitter plus the frame-level expectation for that frame.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int gap);
        int c = sel ? 16 : 1;
        hold(sel, 1'b0, c);
        for (int i = 0; i < 8; i++) hold(sel, b[i], c);
        hold(sel, stop, c);
        if (sel) begin
            if (stop) begin exp16.push_back({1'b0, b}); good16 = b; end
            else            exp16.push_back({1'b1, good16});
        end else begin
            if (stop) begin exp1.push_back({1'b0, b}); good1 = b; end
            else            exp1.push_back({1'b1, good1});
        end
        if (gap > 0) hold(sel, 1'b1, gap * c);
    endtask

    task automatic check_queue(input bit sel, input string name);
        logic [8:0] o[$], e[$];
        int c = sel ? 16 : 1;
        repeat (2 * c + 8) @(negedge clk);
        if (sel) begin o = obs16; e = exp16; obs16.delete(); exp16.delete(); end
        else     begin o = obs1;  e = exp1;  obs1.delete();  exp1.delete();  end
        check({name, "_count"}, o.size(), e.size());
        for (int i = 0; i < o.size() && i < e.size(); i++)
            check($sformatf("%s_ev%0d", name, i), o[i], e[i]);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         n;
        logic       saw_busy;
        logic [7:0] c3;

        tbl[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5};
        tbl[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};   // back-to-back
        tbl[2] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
        tbl[3] = '{8'h3C, 1'b1, 1, 1'b0, 8'h3C};
        tbl[4] = '{8'h55, 1'b0, 1, 1'b1, 8'h3C};   // bad stop, data_out held
        tbl[5] = '{8'h12, 1'b1, 2, 1'b0, 8'h12};

        if1.rx_line  = 1'b1;
        if16.rx_line = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data1",  if1.data_out,    0);
        check("rst_dv1",    if1.data_valid,  0);
        check("rst_fe1",    if1.frame_err,   0);
        check("rst_busy1",  if1.busy,        0);
        check("rst_data16", if16.data_out,   0);
        check("rst_dv16",   if16.data_valid, 0);
        check("rst_fe16",   if16.frame_err,  0);
        check("rst_busy16", if16.busy,       0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table: one-bit-per-clk frames incl. back-to-back and a framing error.
        for (int i = 0; i < 6; i++) send_frame(0, tbl[i].b, tbl[i].stop, tbl[i].gap);
        repeat (10) @(negedge clk);
        check("tbl_count", obs1.size(), 6);
        for (int i = 0; i < 6 && i < obs1.size(); i++) begin
            check($sformatf("tbl%0d_err", i),  obs1[i][8],   tbl[i].exp_err);
            check($sformatf("tbl%0d_data", i), obs1[i][7:0], tbl[i].exp_data);
        end
        check("tbl_busy_after", if1.busy, 0);
        obs1.delete();
        exp1.delete();

        // Latency at 16 clks/bit, counted in posedges from the falling edge.
        n = 0;
        fork
            send_frame(1, 8'h81, 1'b1, 1);
            begin
                while (!if16.data_valid && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        check("lat16_cycles", n, SYNC + 7 + 144 + 1);
        check("lat16_data", if16.data_out, 8'h81);
        check_queue(1, "lat16");

        // 3-cycle glitch: START must abort silently.
        saw_busy = 1'b0;
        hold(1, 1'b0, 3);
        set_line(1, 1'b1);
        repeat (40) begin
            @(negedge clk);
            if (if16.busy) saw_busy = 1'b1;
        end
        check("glitch_saw_busy", saw_busy, 1);
        check("glitch_busy_end", if16.busy, 0);
        check_queue(1, "glitch");

        // Bad stop then line held low: one frame_err, then a clean frame.
        send_frame(1, 8'h55, 1'b0, 0);
        hold(1, 1'b0, 40);
        hold(1, 1'b1, 32);
        send_frame(1, 8'h12, 1'b1, 2);
        check_queue(1, "brk");

        // Reset in the middle of a frame.
        c3 = 8'hC3;
        hold(1, 1'b0, 16);
        for (int i = 0; i < 4; i++) hold(1, c3[i], 16);
        check("mid_busy", if16.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_data16", if16.data_out, 0);
        check("mid_rst_busy16", if16.busy, 0);
        check("mid_rst_data1",  if1.data_out, 0);
        good1  = 8'h00;
        good16 = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        hold(1, 1'b1, 32);
        send_frame(1, 8'h5A, 1'b1, 2);
        check_queue(1, "mid");
        check("mid_data_after", if16.data_out, 8'h5A);

        // Random frames on both receivers.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 25; i++) begin
                logic [7:0] b;
                logic       stop;
                int         gap;
                b    = 8'($urandom);
                stop = ($urandom_range(0, 4) != 0);
                gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                send_frame(s[0], b, stop, gap);
            end
            check_queue(s[0], s[0] ? "rand16" : "rand1");
        end

        check("pulse_shape1",  pulse_bad1,  0);
        check("pulse_shape16", pulse_bad16, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream stage of the lab UART transmitter.
- Consumes the transmitter's tx_line: idle-high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Deserialises each frame into a byte with a one-cycle valid strobe. Flags framing errors.
- Default timing matches the transmitter's one-bit-per-clk output. CLKS_PER_BIT covers divided-baud links.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit; legal range 1..1023.
- SYNC_STAGES, 2, synchroniser depth on rx_line; legal range 2..3.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_line  input  1  serial input; idle 1
- data_out  output  8  last correctly received byte; held until the next good frame
- data_valid  output  1  one-cycle pulse, data_out updated this cycle
- frame_err  output  1  one-cycle pulse, stop bit sampled as 0
- busy  output  1  high from start detection until the frame ends (good or bad)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - All synchroniser flops reset to 1 (idle).
  - data_out=8'h00, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
- Synchroniser: rx_s = rx_line delayed by SYNC_STAGES flops. All decisions use rx_s only.
- Timing reference: T0 = the first cycle rx_s=0 while in IDLE. HALF = (CLKS_PER_BIT-1)/2, integer division.
  - Start bit sampled at T0+HALF.
  - Data bit k (k=0..7) sampled at T0+HALF+(k+1)*CLKS_PER_BIT into bit k.
  - Stop bit sampled at T0+HALF+9*CLKS_PER_BIT.
- States:
  - IDLE: busy=0. rx_s=0 -> START, or directly -> DATA when HALF=0. busy=1 from the cycle after T0.
  - START: count to HALF. If rx_s=1 at the sample -> false start: IDLE, busy=0, no flags. Else -> DATA.
  - DATA: bit counter 0..7; shift sample in LSB-first. After bit 7 -> STOP.
  - STOP: at the sample, rx_s=1 -> data_out<=shift reg, data_valid=1 next cycle, -> IDLE. rx_s=0 -> frame_err=1 next cycle, data_out unchanged, -> BRK.
  - BRK: wait for rx_s=1, then -> IDLE. Protects against a held-low line retriggering.
- Latency: data_valid rises one cycle after the stop-bit sample. Total from rx_line falling edge = SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles.
- Back-to-back: IDLE is re-entered on the stop-sample edge. A start bit on rx_s in the very next cycle is accepted. Required for the transmitter's minimum 1-cycle stop bit at CLKS_PER_BIT=1.
- data_valid and frame_err are never high together and never longer than 1 cycle.
- Output pulse registers are set in the cycle after the stop sample, so they never assert in the same cycle as a new T0.
- No flow control: a consumer missing a data_valid loses the byte; no overrun flag.
- Reset mid-frame: immediate return to reset values; a partial frame is discarded with no flag.
- Bit counter is 4 bits; cycle counter width is $clog2(CLKS_PER_BIT)+1. Neither wraps inside a frame.

Decomposition:
- Shared package uart_pkg:
  - DATA_BITS=8.
  - Default CLKS_PER_BIT=1.
  - rx state enum {IDLE, START, DATA, STOP, BRK}.
  - The same package is also usable by the transmitter.
- One sub-module: uart_sync, an N-stage flop synchroniser with reset value 1, parameter SYNC_STAGES.

Test Plan:
- Loopback with the transmitter, CLKS_PER_BIT=1, send 8'hA5 -> one data_valid pulse, data_out=8'hA5, frame_err never 1, busy low afterwards.
- Back-to-back through the transmitter: 8'h00, 8'hFF, 8'h3C with start_tx re-asserted on the first idle cycle -> three data_valid pulses in order, data_out=00,FF,3C, no frame_err.
- CLKS_PER_BIT=16, driven frame for 8'h81 -> data_valid exactly SYNC_STAGES+7+144+1 cycles after the falling edge, data_out=8'h81.
- CLKS_PER_BIT=16, 3-cycle low glitch -> START aborts, busy returns to 0, no data_valid, no frame_err.
- Frame 8'h55 with stop bit forced 0, line then held low 40 cycles -> single frame_err pulse, data_out keeps its previous value, no retrigger until the line returns high, next good frame 8'h12 received.
- Assert rst after 4 data bits of 8'hC3 -> outputs return to reset values immediately. Following full frame 8'h5A -> data_out=8'h5A.
